// File: rtl/count_uart_pkg.sv
// Shared state encoding, pin map and byte helper for the event counter
// that reports its value over a UART line.
package count_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // ui_in bit positions
  localparam int UI_EVENT = 0;
  localparam int UI_SEND  = 1;
  localparam int UI_CLEAR = 2;

  // uo_out bit positions
  localparam int UO_TX    = 0;
  localparam int UO_BUSY  = 1;
  localparam int UO_OVF   = 2;

  // start + 8 data + stop
  localparam int FRAME_BITS = 10;
  localparam int CNT_BYTES  = 2;

  // Byte 0 is the high byte, byte 1 the low byte of a 16-bit count.
  function automatic logic [7:0] count_byte(input logic [15:0] value, input logic idx);
    return idx ? value[7:0] : value[15:8];
  endfunction

endpackage

// File: rtl/count_uart_if.sv
// Byte handshake between the sequencer and the 8N1 serializer, plus a
// bundle of the standard user-module pins for harness wiring.
interface count_uart_if;
  logic       start;
  logic [7:0] data;
  logic       busy;
  logic       done;
  logic       tx;

  modport master (output start, output data, input busy, input done, input tx);
  modport slave  (input start, input data, output busy, output done, output tx);
endinterface

interface count_uart_pins_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport dut     (input ena, input ui_in, input uio_in,
                   output uo_out, output uio_out, output uio_oe);
  modport harness (output ena, output ui_in, output uio_in,
                   input uo_out, input uio_out, input uio_oe);
endinterface

// File: rtl/count_uart_tx_byte.sv
// 8N1 serializer. A start request seen on the final stop-bit cycle chains
// straight into the next start bit so consecutive bytes have no idle gap.
module count_uart_tx_byte
  import count_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  count_uart_if.slave  link
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_e         state_reg, state_next;
  logic [BAUD_W-1:0] baud_reg, baud_next;
  logic [2:0]        bit_reg, bit_next;
  logic [7:0]        data_reg, data_next;
  logic              baud_last;

  assign baud_last = (baud_reg == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      data_reg  <= data_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg + 1'b1;
    bit_next   = bit_reg;
    data_next  = data_reg;
    link.tx    = 1'b1;
    link.done  = 1'b0;
    link.busy  = (state_reg != IDLE);

    unique case (state_reg)
      IDLE: begin
        baud_next = '0;
        if (link.start) begin
          state_next = START;
          data_next  = link.data;
        end
      end
      START: begin
        link.tx = 1'b0;
        if (baud_last) begin
          state_next = DATA;
          baud_next  = '0;
          bit_next   = '0;
        end
      end
      DATA: begin
        link.tx = data_reg[bit_reg];
        if (baud_last) begin
          baud_next = '0;
          if (bit_reg == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_next = bit_reg + 3'd1;
          end
        end
      end
      STOP: begin
        link.tx = 1'b1;
        if (baud_last) begin
          link.done = 1'b1;
          baud_next = '0;
          if (link.start) begin
            state_next = START;
            data_next  = link.data;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/tt_um_claudiotalarico_count_uart.sv
// Counts synchronized rising edges on an event pin and, on request, sends a
// snapshot of the count as two UART bytes, high byte first.
module tt_um_claudiotalarico_count_uart
  import count_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [2:0] sync_level;
  logic [2:0] sync_rise;

  // Two flops for metastability, a third holds the previous level for edges.
  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_sync
    logic meta_reg, sync_reg, prev_reg;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        meta_reg <= 1'b0;
        sync_reg <= 1'b0;
        prev_reg <= 1'b0;
      end else begin
        meta_reg <= ui_in[gi];
        sync_reg <= meta_reg;
        prev_reg <= sync_reg;
      end
    end

    assign sync_level[gi] = sync_reg;
    assign sync_rise[gi]  = sync_reg & ~prev_reg;
  end

  logic             ev_rise, req_rise, clr_level;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             ovf_reg, ovf_next;
  logic [CNT_W-1:0] snapshot_reg, snapshot_next;
  logic             byte_idx_reg, byte_idx_next;
  logic             accept;

  assign ev_rise   = sync_rise[UI_EVENT];
  assign req_rise  = sync_rise[UI_SEND];
  assign clr_level = sync_level[UI_CLEAR];

  count_uart_if link ();

  count_uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .link  (link)
  );

  // Clear wins over a simultaneous increment.
  always_comb begin
    count_next = count_reg;
    ovf_next   = ovf_reg;
    if (clr_level) begin
      count_next = '0;
      ovf_next   = 1'b0;
    end else if (ev_rise) begin
      count_next = count_reg + 1'b1;
      if (&count_reg) begin
        ovf_next = 1'b1;
      end
    end
  end

  // A new frame sends the live count's high byte directly; the low byte
  // comes from the snapshot so later events cannot leak into the frame.
  always_comb begin
    accept        = req_rise & ~link.busy;
    link.start    = accept | (link.done & ~byte_idx_reg);
    link.data     = accept ? count_byte(count_reg, 1'b0) : count_byte(snapshot_reg, 1'b1);
    snapshot_next = accept ? count_reg : snapshot_reg;
    byte_idx_next = byte_idx_reg;
    if (accept) begin
      byte_idx_next = 1'b0;
    end else if (link.done) begin
      byte_idx_next = ~byte_idx_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg    <= '0;
      ovf_reg      <= 1'b0;
      snapshot_reg <= '0;
      byte_idx_reg <= 1'b0;
    end else begin
      count_reg    <= count_next;
      ovf_reg      <= ovf_next;
      snapshot_reg <= snapshot_next;
      byte_idx_reg <= byte_idx_next;
    end
  end

  always_comb begin
    uo_out          = '0;
    uo_out[UO_TX]   = link.tx;
    uo_out[UO_BUSY] = link.busy;
    uo_out[UO_OVF]  = ovf_reg;
  end

  assign uio_out = count_reg[7:0];
  assign uio_oe  = 8'hFF;

  logic unused_inputs;
  assign unused_inputs = &{1'b0, ena, uio_in, ui_in[7:3], sync_rise[UI_CLEAR],
                           sync_level[UI_EVENT], sync_level[UI_SEND]};

endmodule

// File: tb/tb_tt_um_claudiotalarico_count_uart.sv
// Randomized scoreboard bench: requests push expected bytes, a UART monitor
// decodes the tx line and pops/compares, a second monitor checks busy length.
module tb_tt_um_claudiotalarico_count_uart;
  import count_uart_pkg::*;

  localparam int CPB        = 16;
  localparam int FRAME_CYCS = CNT_BYTES * FRAME_BITS * CPB;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  count_uart_pins_if pins ();

  tt_um_claudiotalarico_count_uart #(
    .CLKS_PER_BIT(CPB),
    .CNT_W(16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (pins.ena),
    .ui_in   (pins.ui_in),
    .uo_out  (pins.uo_out),
    .uio_in  (pins.uio_in),
    .uio_out (pins.uio_out),
    .uio_oe  (pins.uio_oe)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  exp_q[$];
  logic        mon_en   = 1'b0;

  // Reference model state
  logic [15:0] model_count = 16'd0;
  logic        model_ovf   = 1'b0;
  logic        model_clr   = 1'b0;
  int unsigned free_edge   = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_event();
    pins.ui_in[UI_EVENT] = 1'b1;
    tick(2);
    pins.ui_in[UI_EVENT] = 1'b0;
    tick(2);
    if (!model_clr) begin
      if (model_count == 16'hFFFF) model_ovf = 1'b1;
      model_count = model_count + 16'd1;
    end
  endtask

  task automatic clear_hold(input int n);
    pins.ui_in[UI_CLEAR] = 1'b1;
    model_clr   = 1'b1;
    model_count = 16'd0;
    model_ovf   = 1'b0;
    tick(n);
    pins.ui_in[UI_CLEAR] = 1'b0;
    tick(3);
    model_clr = 1'b0;
  endtask

  // A request pin raised at negedge n is acted on at posedge n+3; it is
  // taken only once the previous frame has fully returned to idle.
  task automatic request();
    int unsigned e3;
    e3 = cyc + 3;
    pins.ui_in[UI_SEND] = 1'b1;
    if (e3 >= free_edge) begin
      exp_q.push_back(model_count[15:8]);
      exp_q.push_back(model_count[7:0]);
      free_edge = e3 + FRAME_CYCS + 1;
      $display("request @%0d accepted, snapshot 0x%04h", e3, model_count);
    end else begin
      $display("request @%0d rejected (busy until %0d)", e3, free_edge);
    end
    tick(2);
    pins.ui_in[UI_SEND] = 1'b0;
    tick(2);
  endtask

  task automatic wait_idle();
    while (cyc < free_edge + 2) @(negedge clk);
    check("idle_tx", pins.uo_out[UO_TX], 1'b1);
    check("idle_busy", pins.uo_out[UO_BUSY], 1'b0);
  endtask

  task automatic wait_until(input int unsigned target);
    while (cyc < target) @(negedge clk);
  endtask

  // UART receiver: mid-bit sampling on the falling clock edge.
  initial begin : uart_monitor
    logic       tx_prev;
    logic [7:0] rx;
    tx_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && tx_prev && !pins.uo_out[UO_TX]) begin
        tick(CPB / 2);
        check("start_bit", pins.uo_out[UO_TX], 1'b0);
        for (int i = 0; i < 8; i++) begin
          tick(CPB);
          rx[i] = pins.uo_out[UO_TX];
        end
        tick(CPB);
        check("stop_bit", pins.uo_out[UO_TX], 1'b1);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rx_unexpected: got byte 0x%02h expected no byte", rx);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          $display("rx byte 0x%02h (expected 0x%02h)", rx, e);
          check("rx_byte", rx, e);
        end
      end
      tx_prev = pins.uo_out[UO_TX];
    end
  end

  initial begin : busy_monitor
    int run;
    run = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        run = 0;
      end else if (pins.uo_out[UO_BUSY]) begin
        run++;
      end else if (run != 0) begin
        check("busy_len", run, FRAME_CYCS);
        run = 0;
      end
    end
  end

  initial begin : watchdog
    #(10 * 200000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int nev;
    pins.ena    = 1'b1;
    pins.ui_in  = 8'h00;
    pins.uio_in = 8'h00;
    rst_n       = 1'b0;

    // Reset state
    tick(5);
    check("rst_uo_out", pins.uo_out, 8'h01);
    check("rst_uio_out", pins.uio_out, 8'h00);
    check("rst_uio_oe", pins.uio_oe, 8'hFF);
    rst_n = 1'b1;
    tick(2);

    // Reset in the middle of a frame
    pins.ui_in[UI_SEND] = 1'b1;
    tick(2);
    pins.ui_in[UI_SEND] = 1'b0;
    tick(60);
    check("mid_busy", pins.uo_out[UO_BUSY], 1'b1);
    rst_n = 1'b0;
    tick(1);
    check("abort_tx", pins.uo_out[UO_TX], 1'b1);
    check("abort_busy", pins.uo_out[UO_BUSY], 1'b0);
    rst_n = 1'b1;
    tick(2);
    mon_en = 1'b1;

    // Counting, then report
    repeat (5) pulse_event();
    check("count5", pins.uio_out, model_count[7:0]);
    request();
    wait_idle();

    // Snapshot isolation
    clear_hold(4);
    repeat (258) pulse_event();
    check("count_0102", pins.uio_out, model_count[7:0]);
    request();
    repeat (3) pulse_event();
    wait_idle();
    check("count_after_frame", pins.uio_out, model_count[7:0]);

    // Randomized rounds
    for (int r = 0; r < 6; r++) begin
      if ($urandom_range(0, 3) == 0) clear_hold($urandom_range(1, 6));
      nev = $urandom_range(0, 20);
      repeat (nev) pulse_event();
      request();
      nev = $urandom_range(0, 6);
      repeat (nev) pulse_event();
      if ($urandom_range(0, 2) == 0) clear_hold(2);
      wait_idle();
      check("rand_count", pins.uio_out, model_count[7:0]);
      check("rand_ovf", pins.uo_out[UO_OVF], model_ovf);
    end

    // Wrap and sticky overflow, starting near the top of the range
    force dut.count_reg = 16'hFFF0;
    tick(1);
    release dut.count_reg;
    model_count = 16'hFFF0;
    model_ovf   = 1'b0;
    tick(1);
    check("preload", pins.uio_out, 8'hF0);
    repeat (15) pulse_event();
    check("pre_wrap_count", pins.uio_out, model_count[7:0]);
    check("pre_wrap_ovf", pins.uo_out[UO_OVF], model_ovf);
    pulse_event();
    check("wrap_count", pins.uio_out, model_count[7:0]);
    check("wrap_ovf", pins.uo_out[UO_OVF], model_ovf);
    pulse_event();
    check("sticky_ovf", pins.uo_out[UO_OVF], model_ovf);
    request();
    wait_idle();
    clear_hold(4);
    check("clr_ovf", pins.uo_out[UO_OVF], model_ovf);
    check("clr_count", pins.uio_out, model_count[7:0]);

    // Clear held while events arrive
    pins.ui_in[UI_CLEAR] = 1'b1;
    model_clr   = 1'b1;
    model_count = 16'd0;
    model_ovf   = 1'b0;
    tick(4);
    repeat (4) pulse_event();
    pins.ui_in[UI_CLEAR] = 1'b0;
    tick(4);
    model_clr = 1'b0;
    check("clr_vs_event", pins.uio_out, model_count[7:0]);
    pulse_event();
    check("after_clr_event", pins.uio_out, model_count[7:0]);

    // Busy rejection and the accept boundary
    request();
    tick(96);
    request();
    wait_until(free_edge - 4);
    request();
    wait_idle();
    request();
    wait_until(free_edge - 3);
    request();
    wait_idle();

    tick(FRAME_CYCS + 80);
    check("pending_bytes", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tt_um_claudiotalarico_count_uart.md
Name: tt_um_claudiotalarico_count_uart

Overview:
- Tiny Tapeout user design that counts rising edges on an external event pin and, on request, sends a snapshot of the count as two UART 8N1 bytes (high byte first).
- It is the transmitting end paired with the existing counter design: the counter generates values, this block reports them off-chip over a single serial line.
- Uses the standard TT user-module pin set; the cocotb bench drives it through the usual tb wrapper.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit (minimum 2).
- CNT_W, 16, event counter width; fixed at 16 so the count fits two bytes.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset: one clock; reset is synchronous and active-low.
- ena  in  1  design selected; ignored, and the design must not gate anything on it.
- ui_in  in  8  [0] event, [1] send request, [2] clear; [7:3] unused.
- uo_out  out  8  [0] tx line (idle high), [1] busy, [2] overflow flag; [7:3] = 0.
- uio_in  in  8  unused.
- uio_out  out  8  low byte of the live counter.
- uio_oe  out  8  constant 8'hFF.

Behaviour:
- Reset (rst_n low at a clock edge): count=0, overflow=0, tx=1, busy=0, FSM=IDLE, synchronizer flops=0. Reset mid-frame aborts the frame; tx is high after that edge.
- ui_in[2:0] each pass through a 2-FF synchronizer. A third flop holds the previous synced value for edge detection.
- Event: a synced rising edge on ui_in[0] increments count; the new value appears on uio_out 3 clock edges after the pin is first sampled high. A minimum pulse width of 1 clk high and 1 clk low is required.
- Wrap: 16'hFFFF+1 gives 0 and sets overflow. Overflow is sticky until clear or reset.
- Clear: while synced ui_in[2] is high (level), count=0 and overflow=0. Clear has priority over a simultaneous increment.
- Send: a synced rising edge of ui_in[1] while FSM=IDLE captures snapshot=count, with any same-cycle increment excluded, and enters START.
  - A request edge while busy is ignored, not queued.
  - Events and clears during transmission still update count; the snapshot is unaffected.
- FSM states: IDLE, START, DATA, STOP, with a byte index (0=high byte, 1=low byte) and a bit index 0..7.
  - IDLE: tx=1.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx=byte[bit], LSB first, CLKS_PER_BIT cycles per bit. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then, if byte index=0, set it to 1 and go to START (no idle gap); otherwise go to IDLE.
- Latency: tx falls on the 3rd clock edge at which ui_in[1] is sampled high after being low.
- Busy is high from entry to START until the last STOP cycle completes. Total frame = 20*CLKS_PER_BIT cycles (320 by default).
- Busy=0 on the cycle IDLE is re-entered; a new request edge is accepted from that cycle onward.
- Baud counter: counts 0..CLKS_PER_BIT-1 and resets on every state or bit change.

Decomposition:
- Package count_uart_pkg holds:
  - the FSM state enum (IDLE, START, DATA, STOP);
  - the ui_in/uo_out bit-index constants;
  - constant FRAME_BITS=10.
- One sub-module, count_uart_tx_byte: an 8N1 serializer with a start/data/busy/done handshake and parameter CLKS_PER_BIT.
- The top module owns the synchronizers, counter, snapshot, and 2-byte sequencing.

Test Plan:
- Reset check: hold rst_n=0 for 5 clocks -> uo_out=8'h01, uio_out=0, uio_oe=8'hFF. Then pulse ui_in[1] mid-frame and reassert reset -> tx=1 and busy=0 the next cycle.
- Counting: 5 event pulses (2 clk high, 2 clk low) -> uio_out=5. Then a request -> decoded bytes 0x00 then 0x05, busy high for exactly 320 cycles, tx idle high afterwards.
- Snapshot isolation: count=0x0102, request, then 3 events during the frame -> bytes 0x01, 0x02; uio_out=0x05 after.
- Wrap/overflow: 65536 events -> uio_out=0, uo_out[2]=1. Then clear high for 4 clocks -> uo_out[2]=0.
- Clear vs. event: clear held high while 4 events arrive -> count stays 0. Release clear, 1 event -> count=1.
- Busy rejection: second request 100 cycles into a frame -> exactly 2 bytes sent. A request on the cycle busy falls starts a new frame.
